// File: rtl/lsu_dmem_adapter.sv
// lsu_dmem_adapter: turns byte/half/word/dword CPU loads and stores into
// 64-bit dword-aligned accesses on the data port of the 2R1W RAM. An access
// that spills past a dword boundary is split into two back-to-back RAM
// accesses (ACC0 for the low dword, ACC1 for the next one).
// Optional feature: define LSU_MISALIGN_TRAP_EN to answer misaligned requests
// with resp_err=1 and no RAM traffic instead of splitting them.
module lsu_dmem_adapter #(
  parameter int ADDR_W = 64,
  parameter int XLEN   = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_wen,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic              dmem_en,
  output logic [ADDR_W-1:0] dmem_addr,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic [XLEN-1:0]   dmem_wmask,
  output logic              dmem_wen
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   addr_reg;
  logic                wen_reg;
  logic [1:0]          size_reg;
  logic                signed_reg;
  logic [XLEN-1:0]     wdata_reg;
  logic [XLEN-1:0]     lo_reg;
  logic [XLEN-1:0]     hi_reg;
  logic                err_reg;

  logic [2:0]          off;
  logic [3:0]          nbytes;
  logic                crossing;
  logic [7:0]          size_lanes;
  logic [15:0]         lane_span;
  logic [2*XLEN-1:0]   wdata_span;
  logic [XLEN-1:0]     rd_aligned;
  logic [ADDR_W-1:0]   base_addr;
  logic [7:0]          lane_sel;
  logic                req_mis;

  // Request geometry derived from the latched request. The two halves of the
  // 16-lane span / 128-bit shifted data map directly onto ACC0 and ACC1.
  assign off        = addr_reg[2:0];
  assign nbytes     = 4'd1 << size_reg;
  assign crossing   = ({1'b0, off} + nbytes) > 4'd8;
  assign lane_span  = {8'b0, size_lanes} << off;
  assign wdata_span = {{XLEN{1'b0}}, wdata_reg} << {off, 3'b000};
  assign rd_aligned = XLEN'({hi_reg, lo_reg} >> {off, 3'b000});
  assign base_addr  = {addr_reg[ADDR_W-1:3], 3'b000};

  // Contiguous low-lane mask for the access size.
  always_comb begin
    size_lanes = 8'h01;
    case (size_reg)
      2'd0: size_lanes = 8'h01;
      2'd1: size_lanes = 8'h03;
      2'd2: size_lanes = 8'h0F;
      2'd3: size_lanes = 8'hFF;
      default: size_lanes = 8'h01;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // Misalignment of the incoming request: any address bit below nbytes set.
  always_comb begin
    req_mis = 1'b0;
    case (req_size)
      2'd0: req_mis = 1'b0;
      2'd1: req_mis = req_addr[0];
      2'd2: req_mis = |req_addr[1:0];
      2'd3: req_mis = |req_addr[2:0];
      default: req_mis = 1'b0;
    endcase
  end
`else
  assign req_mis = 1'b0;
`endif

  // Expand each enabled byte lane into eight mask bits.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_mask
      assign dmem_wmask[gi*8 +: 8] = {8{lane_sel[gi]}};
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic and RAM-side / handshake outputs.
  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    dmem_en    = 1'b0;
    dmem_wen   = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    lane_sel   = 8'h00;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = req_mis ? RESP : ACC0;
      end
      ACC0: begin
        dmem_en   = 1'b1;
        dmem_addr = base_addr;
        if (wen_reg) begin
          dmem_wen   = 1'b1;
          dmem_wdata = wdata_span[XLEN-1:0];
          lane_sel   = lane_span[7:0];
        end
        state_next = crossing ? ACC1 : RESP;
      end
      ACC1: begin
        dmem_en   = 1'b1;
        dmem_addr = base_addr + ADDR_W'(8);
        if (wen_reg) begin
          dmem_wen   = 1'b1;
          dmem_wdata = wdata_span[2*XLEN-1:XLEN];
          lane_sel   = lane_span[15:8];
        end
        state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latch and load data capture; hi is cleared on accept so a
  // non-crossing load shifts in zeros above lo.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg   <= '0;
      wen_reg    <= 1'b0;
      size_reg   <= 2'd0;
      signed_reg <= 1'b0;
      wdata_reg  <= '0;
      lo_reg     <= '0;
      hi_reg     <= '0;
      err_reg    <= 1'b0;
    end else begin
      if (state_reg == IDLE && req_valid) begin
        addr_reg   <= req_addr;
        wen_reg    <= req_wen;
        size_reg   <= req_size;
        signed_reg <= req_signed;
        wdata_reg  <= req_wdata;
        lo_reg     <= '0;
        hi_reg     <= '0;
        err_reg    <= req_mis;
      end
      if (state_reg == ACC0 && !wen_reg) lo_reg <= dmem_rdata;
      if (state_reg == ACC1 && !wen_reg) hi_reg <= dmem_rdata;
    end
  end

  // Response data: extract the addressed bytes and extend; zero for stores
  // and trapped requests.
  always_comb begin
    resp_rdata = '0;
    resp_err   = (state_reg == RESP) && err_reg;
    if (state_reg == RESP && !wen_reg && !err_reg) begin
      case (size_reg)
        2'd0: resp_rdata = {{(XLEN-8){signed_reg & rd_aligned[7]}}, rd_aligned[7:0]};
        2'd1: resp_rdata = {{(XLEN-16){signed_reg & rd_aligned[15]}}, rd_aligned[15:0]};
        2'd2: resp_rdata = {{(XLEN-32){signed_reg & rd_aligned[31]}}, rd_aligned[31:0]};
        default: resp_rdata = rd_aligned;
      endcase
    end
  end

endmodule
